// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
//   DEPTH-entry instruction queue sitting between fetch (IF) and decode (ID).
//   Each entry holds a raw 32-bit RV32 instruction and its PC. Both sides use
//   valid/ready handshakes. A front-end flush empties the queue. The head entry
//   is presented to ID both as a raw word and pre-split into RV32 fields.
//
//   Optional build macro: IFQ_BUBBLE_NOP_EN
//     When defined, the head outputs show the canonical NOP (0x00000013,
//     pc 0) whenever the queue is empty, so ID can ignore out_valid for
//     hazard decisions. When undefined, an empty queue shows stale storage.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   fetch presents an instruction
//   in_ready   out  queue can accept (count < DEPTH)
//   in_inst    in   raw instruction word
//   in_pc      in   PC of in_inst
//   flush      in   discard all queued and incoming instructions
//   out_valid  out  head entry valid (count != 0)
//   out_ready  in   ID consumes head
//   opcode_ID, rd_ID, funct3, rs1_ID, rs2_ID, funct7   out  head fields
//   out_inst   out  head raw instruction
//   out_pc     out  head PC
//   count      out  current occupancy
// ---------------------------------------------------------------------------
module if_id_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       opcode_ID,
    output logic [4:0]       rd_ID,
    output logic [2:0]       funct3,
    output logic [4:0]       rs1_ID,
    output logic [4:0]       rs2_ID,
    output logic [6:0]       funct7,
    output logic [31:0]      out_inst,
    output logic [XLEN-1:0]  out_pc,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      mem_inst [DEPTH];
    logic [XLEN-1:0]  mem_pc   [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    logic [31:0]      head_inst;
    logic [XLEN-1:0]  head_pc;

    // Handshake flags come from occupancy alone: no in->out combinational path.
    assign in_ready  = (count < CNT_W'(DEPTH));
    assign out_valid = (count != '0);

    // Flush overrides both transfers in the same cycle.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_inst[i] <= '0;
                mem_pc[i]   <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_inst[wr_ptr] <= in_inst;
                mem_pc[wr_ptr]   <= in_pc;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_comb begin
        head_inst = mem_inst[rd_ptr];
        head_pc   = mem_pc[rd_ptr];
`ifdef IFQ_BUBBLE_NOP_EN
        // Empty queue presents a bubble so ID sees a harmless NOP.
        if (!out_valid) begin
            head_inst = 32'h0000_0013;
            head_pc   = '0;
        end
`else
`endif
    end

    assign out_inst  = head_inst;
    assign out_pc    = head_pc;
    assign opcode_ID = head_inst[6:0];
    assign rd_ID     = head_inst[11:7];
    assign funct3    = head_inst[14:12];
    assign rs1_ID    = head_inst[19:15];
    assign rs2_ID    = head_inst[24:20];
    assign funct7    = head_inst[31:25];

endmodule
